// File: rtl/day_time_pkg.sv
// Shared types, constants and calendar helpers for the day/time record parser.
// The calendar helpers are only referenced when DAY_MONTH_CHECK_EN is defined.
package day_time_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_YEAR  = 4'd1,
    ST_SEP_Y = 4'd2,
    ST_MON   = 4'd3,
    ST_SEP_M = 4'd4,
    ST_DAY   = 4'd5,
    ST_SEP_D = 4'd6,
    ST_HOUR  = 4'd7,
    ST_SEP_H = 4'd8,
    ST_MIN   = 4'd9,
    ST_DONE  = 4'd10,
    ST_ERR   = 4'd11
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  localparam logic [7:0] MON_MAX  = 8'h12;
  localparam logic [7:0] DAY_MAX  = 8'h31;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  // A two-digit BCD value 10*t+u is a multiple of 4 when t is even and
  // u is 0/4/8, or t is odd and u is 2/6. Bit 4 is the parity of t.
  function automatic logic bcd_div4(input logic [7:0] b);
    if (b[4]) return (b[3:0] == 4'd2) || (b[3:0] == 4'd6);
    else      return (b[3:0] == 4'd0) || (b[3:0] == 4'd4) || (b[3:0] == 4'd8);
  endfunction

  // Last legal day of a BCD month, in BCD.
  function automatic logic [7:0] days_in_month(input logic [7:0] mon, input logic leap);
    case (mon)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/day_bcd_field.sv
// Two-digit BCD shift accumulator for one record field. o_value already
// includes the digit being accepted this cycle, so the parent can load or
// range-check a field on the same edge that completes it.
module day_bcd_field (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_shift,
  input  logic [3:0] i_digit,
  input  logic [7:0] i_min,
  input  logic [7:0] i_max,
  output logic [7:0] o_value,
  output logic       o_complete,
  output logic       o_in_range
);

  logic [7:0] r_acc;
  logic [1:0] r_cnt;
  logic [7:0] w_next;

  assign w_next     = {r_acc[3:0], i_digit};
  assign o_value    = i_shift ? w_next : r_acc;
  assign o_complete = i_shift && (r_cnt == 2'd1);
  assign o_in_range = (w_next >= i_min) && (w_next <= i_max);

  // Accumulate digits; cleared when a new record starts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= 8'h00;
      r_cnt <= 2'd0;
    end else if (i_clr) begin
      r_acc <= 8'h00;
      r_cnt <= 2'd0;
    end else if (i_shift) begin
      r_acc <= w_next;
      r_cnt <= r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/day_time_parser.sv
// Streaming recognizer for YYYY/MM/DD and YYYY/MM/DD/HH/MM records.
// Handshake: in_char is consumed on a rising clk edge exactly when in_valid
// is high; there is no back-pressure, the parser accepts every valid cycle.
// Optional build macro DAY_MONTH_CHECK_EN: check the day against the
// length of the month (with leap years) instead of only 01..31.
module day_time_parser
  import day_time_pkg::*;
#(
  parameter int         YEAR_DIGITS = 4,
  parameter logic [7:0] SEP         = 8'h2F
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_char,
  input  logic                     fmt,
  output logic                     match,
  output logic                     err,
  output logic [4*YEAR_DIGITS-1:0] year,
  output logic [7:0]               month,
  output logic [7:0]               dayv,
  output logic [7:0]               hour,
  output logic [7:0]               minute
);

  localparam logic [2:0] YCNT_LAST = 3'(YEAR_DIGITS - 1);

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_fmt;
  logic [4*YEAR_DIGITS-1:0] r_year_acc;
  logic [2:0]               r_year_cnt;

  logic w_is_digit, w_is_sep, w_is_other, w_start, w_load, w_day_ok;
  logic [7:0] w_mon_val, w_day_val, w_hour_val, w_min_val;
  logic w_mon_cmp, w_day_cmp, w_hour_cmp, w_min_cmp;
  logic w_mon_rng, w_day_rng, w_hour_rng, w_min_rng;

  assign w_is_digit = (in_char >= ASCII_0) && (in_char <= ASCII_9);
  assign w_is_sep   = (in_char == SEP);
  assign w_is_other = !w_is_digit && !w_is_sep;
  assign w_start    = in_valid && w_is_digit && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_load     = in_valid && (w_next == ST_DONE) &&
                      ((r_state == ST_DAY) || (r_state == ST_MIN));

  day_bcd_field u_mon (
    .i_clk(clk), .i_rst_n(reset), .i_clr(w_start),
    .i_shift(in_valid && w_is_digit && (r_state == ST_MON)),
    .i_digit(in_char[3:0]), .i_min(8'h01), .i_max(MON_MAX),
    .o_value(w_mon_val), .o_complete(w_mon_cmp), .o_in_range(w_mon_rng)
  );

  day_bcd_field u_day (
    .i_clk(clk), .i_rst_n(reset), .i_clr(w_start),
    .i_shift(in_valid && w_is_digit && (r_state == ST_DAY)),
    .i_digit(in_char[3:0]), .i_min(8'h01), .i_max(DAY_MAX),
    .o_value(w_day_val), .o_complete(w_day_cmp), .o_in_range(w_day_rng)
  );

  day_bcd_field u_hour (
    .i_clk(clk), .i_rst_n(reset), .i_clr(w_start),
    .i_shift(in_valid && w_is_digit && (r_state == ST_HOUR)),
    .i_digit(in_char[3:0]), .i_min(8'h00), .i_max(HOUR_MAX),
    .o_value(w_hour_val), .o_complete(w_hour_cmp), .o_in_range(w_hour_rng)
  );

  day_bcd_field u_min (
    .i_clk(clk), .i_rst_n(reset), .i_clr(w_start),
    .i_shift(in_valid && w_is_digit && (r_state == ST_MIN)),
    .i_digit(in_char[3:0]), .i_min(8'h00), .i_max(MIN_MAX),
    .o_value(w_min_val), .o_complete(w_min_cmp), .o_in_range(w_min_rng)
  );

`ifdef DAY_MONTH_CHECK_EN
  logic [15:0] w_year_pad;
  logic        w_leap;
  assign w_year_pad = 16'(r_year_acc);
  // Century years (low digits 00) are leap only if the century is a multiple of 4.
  assign w_leap   = bcd_div4(w_year_pad[7:0]) &&
                    ((w_year_pad[7:0] != 8'h00) || (YEAR_DIGITS != 4) ||
                     bcd_div4(w_year_pad[15:8]));
  assign w_day_ok = w_day_rng && (w_day_val <= days_in_month(w_mon_val, w_leap));
`else
  assign w_day_ok = w_day_rng;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; nothing moves unless a character is accepted.
  always_comb begin
    w_next = r_state;
    if (in_valid) begin
      case (r_state)
        ST_IDLE:  if (w_is_digit) w_next = ST_YEAR;
        ST_YEAR:  if (!w_is_digit) w_next = ST_ERR;
                  else if (r_year_cnt == YCNT_LAST) w_next = ST_SEP_Y;
        ST_MON:   if (!w_is_digit) w_next = ST_ERR;
                  else if (w_mon_cmp) w_next = w_mon_rng ? ST_SEP_M : ST_ERR;
        ST_DAY:   if (!w_is_digit) w_next = ST_ERR;
                  else if (w_day_cmp) w_next = !w_day_ok ? ST_ERR : (r_fmt ? ST_SEP_D : ST_DONE);
        ST_HOUR:  if (!w_is_digit) w_next = ST_ERR;
                  else if (w_hour_cmp) w_next = w_hour_rng ? ST_SEP_H : ST_ERR;
        ST_MIN:   if (!w_is_digit) w_next = ST_ERR;
                  else if (w_min_cmp) w_next = w_min_rng ? ST_DONE : ST_ERR;
        ST_SEP_Y: w_next = w_is_sep ? ST_MON  : ST_ERR;
        ST_SEP_M: w_next = w_is_sep ? ST_DAY  : ST_ERR;
        ST_SEP_D: w_next = w_is_sep ? ST_HOUR : ST_ERR;
        ST_SEP_H: w_next = w_is_sep ? ST_MIN  : ST_ERR;
        ST_DONE:  w_next = w_is_digit ? ST_YEAR : ST_ERR;
        ST_ERR:   if (w_is_other) w_next = ST_IDLE;
        default:  w_next = ST_ERR;
      endcase
    end
  end

  // Year shift register, digit count and format latch for the current record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_year_acc <= '0;
      r_year_cnt <= 3'd0;
      r_fmt      <= 1'b0;
    end else if (w_start) begin
      r_year_acc <= {{(4*YEAR_DIGITS-4){1'b0}}, in_char[3:0]};
      r_year_cnt <= 3'd1;
      r_fmt      <= fmt;
    end else if (in_valid && w_is_digit && (r_state == ST_YEAR)) begin
      r_year_acc <= {r_year_acc[4*YEAR_DIGITS-5:0], in_char[3:0]};
      r_year_cnt <= r_year_cnt + 3'd1;
    end
  end

  // Registered status flags and decoded fields; fields change only on DONE entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match  <= 1'b0;
      err    <= 1'b0;
      year   <= '0;
      month  <= 8'h00;
      dayv   <= 8'h00;
      hour   <= 8'h00;
      minute <= 8'h00;
    end else begin
      match <= (w_next == ST_DONE);
      err   <= (w_next == ST_ERR);
      if (w_load) begin
        year   <= r_year_acc;
        month  <= w_mon_val;
        dayv   <= w_day_val;
        hour   <= r_fmt ? w_hour_val : 8'h00;
        minute <= r_fmt ? w_min_val  : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_day_time_parser.sv
// Directed bench for day_time_parser (default parameters). Expectations for
// the day-versus-month cases follow DAY_MONTH_CHECK_EN.
module tb_day_time_parser;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        fmt = 1'b0;
  logic        match, err;
  logic [15:0] year;
  logic [7:0]  month, dayv, hour, minute;

  int checks = 0;
  int errors = 0;

  day_time_parser dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char), .fmt(fmt),
    .match(match), .err(err), .year(year), .month(month), .dayv(dayv),
    .hour(hour), .minute(minute)
  );

  // Clock
  always #5 clk = ~clk;

  // Drivers: inputs change 1 ns after the rising edge, outputs are read there too.
  task automatic send_char(input logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL rst_match: got %b exp 0", match); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err); end
    checks++; if ({year, month, dayv, hour, minute} !== 48'h0) begin
      errors++; $display("FAIL rst_fields: got %h exp 0", {year, month, dayv, hour, minute}); end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_datetime();
    string s;
    s = "0000/10/23/12/23";
    fmt = 1'b1;
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i]);
      checks++;
      if (err !== 1'b0 || match !== (i == s.len() - 1)) begin
        errors++; $display("FAIL dt_char%0d: got match=%b err=%b exp match=%b err=0",
                           i, match, err, (i == s.len() - 1));
      end
    end
    checks++; if (year !== 16'h0000) begin errors++; $display("FAIL dt_year: got %h exp 0000", year); end
    checks++; if (month !== 8'h10) begin errors++; $display("FAIL dt_month: got %h exp 10", month); end
    checks++; if (dayv !== 8'h23) begin errors++; $display("FAIL dt_day: got %h exp 23", dayv); end
    checks++; if (hour !== 8'h12) begin errors++; $display("FAIL dt_hour: got %h exp 12", hour); end
    checks++; if (minute !== 8'h23) begin errors++; $display("FAIL dt_min: got %h exp 23", minute); end
  endtask

  task automatic test_gaps();
    do_reset();
    fmt = 1'b0;
    send_str("2023/1");
    // fmt and in_char wiggle during the gap; neither may be taken.
    fmt = 1'b1;
    in_char = 8'h20;
    idle(3);
    checks++; if (match !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL gap_hold: got match=%b err=%b exp 0 0", match, err); end
    send_str("0/23");
    checks++; if (match !== 1'b1) begin errors++; $display("FAIL gap_match: got %b exp 1", match); end
    checks++; if (year !== 16'h2023) begin errors++; $display("FAIL gap_year: got %h exp 2023", year); end
    checks++; if (month !== 8'h10 || dayv !== 8'h23) begin
      errors++; $display("FAIL gap_md: got %h/%h exp 10/23", month, dayv); end
    checks++; if (hour !== 8'h00 || minute !== 8'h00) begin
      errors++; $display("FAIL gap_hm: got %h:%h exp 00:00", hour, minute); end
    idle(2);
    checks++; if (match !== 1'b1) begin errors++; $display("FAIL gap_done_hold: got %b exp 1", match); end
  endtask

  task automatic test_resync();
    fmt = 1'b0;
    send_str("2021/1");
    checks++; if (match !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rs_pre: got match=%b err=%b exp 0 0", match, err); end
    send_char("3");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rs_err: got %b exp 1", err); end
    checks++; if (year !== 16'h2023 || month !== 8'h10) begin
      errors++; $display("FAIL rs_keep: got %h/%h exp 2023/10", year, month); end
    send_char(" ");
    checks++; if (match !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rs_idle: got match=%b err=%b exp 0 0", match, err); end
    send_str("2021/01/05");
    checks++; if (match !== 1'b1 || month !== 8'h01 || dayv !== 8'h05 || year !== 16'h2021) begin
      errors++; $display("FAIL rs_match: got m=%b %h/%h/%h exp 1 2021/01/05", match, year, month, dayv); end
  endtask

  task automatic test_errors();
    do_reset();
    fmt = 1'b0;
    send_str("2021/");
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL er_sep1: got %b exp 0", err); end
    send_char("/");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL er_sep2: got %b exp 1", err); end
    send_str("5/");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL er_stay: got %b exp 1", err); end
    send_char(" ");
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL er_exit: got %b exp 0", err); end
    fmt = 1'b1;
    send_str("2021/01/01/2");
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL er_h1: got %b exp 0", err); end
    send_char("4");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL er_h24: got %b exp 1", err); end
    send_str("/00 ");
    fmt = 1'b0;
    send_str("2021/00");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL er_mon00: got %b exp 1", err); end
    send_char(" ");
    send_str("2021/01/32");
    checks++; if (err !== 1'b1 || match !== 1'b0) begin
      errors++; $display("FAIL er_day32: got err=%b match=%b exp 1 0", err, match); end
    send_char(" ");
    send_str("2021/01/3x");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL er_other: got %b exp 1", err); end
    send_char(" ");
    fmt = 1'b1;
    send_str("2021/12/31/23/59");
    checks++; if (match !== 1'b1 || hour !== 8'h23 || minute !== 8'h59 || dayv !== 8'h31 || month !== 8'h12) begin
      errors++; $display("FAIL er_maxok: got m=%b %h/%h %h:%h exp 1 12/31 23:59", match, month, dayv, hour, minute); end
    send_char("/");
    checks++; if (err !== 1'b1 || match !== 1'b0) begin
      errors++; $display("FAIL er_done_sep: got err=%b match=%b exp 1 0", err, match); end
    send_char(" ");
  endtask

  task automatic test_back_to_back();
    do_reset();
    fmt = 1'b0;
    send_str("1999/12/31");
    checks++; if (match !== 1'b1) begin errors++; $display("FAIL b2b_m1: got %b exp 1", match); end
    send_char("2");
    checks++; if (match !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL b2b_drop: got match=%b err=%b exp 0 0", match, err); end
    checks++; if (year !== 16'h1999 || month !== 8'h12 || dayv !== 8'h31) begin
      errors++; $display("FAIL b2b_keep: got %h/%h/%h exp 1999/12/31", year, month, dayv); end
    send_str("000/01/01");
    checks++; if (match !== 1'b1 || year !== 16'h2000 || month !== 8'h01 || dayv !== 8'h01) begin
      errors++; $display("FAIL b2b_m2: got m=%b %h/%h/%h exp 1 2000/01/01", match, year, month, dayv); end
  endtask

  task automatic test_async_reset();
    fmt = 1'b1;
    send_str("2024/0");
    #2;
    reset = 1'b0;
    #1;
    checks++; if (match !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL ar_flags: got match=%b err=%b exp 0 0", match, err); end
    checks++; if ({year, month, dayv, hour, minute} !== 48'h0) begin
      errors++; $display("FAIL ar_fields: got %h exp 0", {year, month, dayv, hour, minute}); end
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    fmt = 1'b0;
    send_str("2024/02/29");
    checks++; if (match !== 1'b1 || year !== 16'h2024) begin
      errors++; $display("FAIL ar_restart: got m=%b year=%h exp 1 2024", match, year); end
    send_str("  ");
  endtask

  task automatic test_day_month();
    logic exp_err;
`ifdef DAY_MONTH_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    fmt = 1'b0;
    send_str("2021/02/29");
    checks++; if (err !== exp_err || match !== !exp_err) begin
      errors++; $display("FAIL dm_feb29_2021: got err=%b match=%b exp err=%b", err, match, exp_err); end
    send_str("  ");
    send_str("2000/02/29");
    checks++; if (match !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL dm_feb29_2000: got match=%b err=%b exp 1 0", match, err); end
    send_str("  ");
    send_str("2021/04/31");
    checks++; if (err !== exp_err || match !== !exp_err) begin
      errors++; $display("FAIL dm_apr31: got err=%b match=%b exp err=%b", err, match, exp_err); end
    send_str("  ");
    send_str("1900/02/29");
    checks++; if (err !== exp_err) begin
      errors++; $display("FAIL dm_feb29_1900: got err=%b exp %b", err, exp_err); end
    send_str("  ");
    send_str("2021/04/30");
    checks++; if (match !== 1'b1 || dayv !== 8'h30) begin
      errors++; $display("FAIL dm_apr30: got match=%b day=%h exp 1 30", match, dayv); end
    send_str("  ");
  endtask

  initial begin
    test_reset();
    test_datetime();
    test_gaps();
    test_resync();
    test_errors();
    test_back_to_back();
    test_async_reset();
    test_day_month();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
